// File: rtl/frog_pkg.sv
// Shared types and widths for the frog game round sequencer.
package frog_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PLAY,
        WIN_FLASH,
        LOSS_FLASH,
        GAME_OVER
    } state_t;

    localparam int SCORE_LIMIT = 99;
    localparam int LIVES_W     = 2;
    localparam int SCORE_W     = 7;
    localparam int LEVEL_W     = 3;
    localparam int PERIOD_W    = 5;

endpackage

// File: rtl/frog_round_ctrl_flash_timer.sv
// Loadable down-counter that holds at zero; zero flag marks the last flash cycle.
module flash_timer #(
    parameter int FLASH_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic zero
);

    localparam int W = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
    localparam logic [W-1:0] LOAD_VAL = W'(FLASH_CYCLES - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/frog_round_ctrl.sv
// Round sequencer: lives, score, level and car period for the 16x16 frog game.
// Optional FROG_HISCORE_EN adds a hiscore output latched on entry to GAME_OVER.
module frog_round_ctrl
    import frog_pkg::*;
#(
    parameter int LIVES        = 3,
    parameter int FLASH_CYCLES = 8,
    parameter int MAX_LEVEL    = 7,
    parameter int BASE_PERIOD  = 24,
    parameter int PERIOD_STEP  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                won,
    input  logic                lost,
    output logic                respawn,
    output logic                freeze,
    output logic                flash,
    output logic                win_flash,
    output logic                game_over,
    output logic [LIVES_W-1:0]  lives,
    output logic [SCORE_W-1:0]  score,
    output logic [LEVEL_W-1:0]  level,
    output logic [PERIOD_W-1:0] car_period
`ifdef FROG_HISCORE_EN
    ,
    output logic [SCORE_W-1:0]  hiscore
`endif
);

    localparam logic [LIVES_W-1:0]  LIVES_INIT = LIVES_W'(LIVES);
    localparam logic [SCORE_W-1:0]  SCORE_MAX  = SCORE_W'(SCORE_LIMIT);
    localparam logic [LEVEL_W-1:0]  LEVEL_MAX  = LEVEL_W'(MAX_LEVEL);
    localparam logic [PERIOD_W-1:0] PERIOD_0   = PERIOD_W'(BASE_PERIOD);
    localparam logic [PERIOD_W-1:0] PERIOD_D   = PERIOD_W'(PERIOD_STEP);

    state_t               state, state_nx;
    logic [LIVES_W-1:0]   lives_nx;
    logic [SCORE_W-1:0]   score_nx;
    logic [LEVEL_W-1:0]   level_nx;
    logic [PERIOD_W-1:0]  period_nx;
    logic                 respawn_nx;
    logic                 timer_load;
    logic                 timer_zero;

    flash_timer #(
        .FLASH_CYCLES(FLASH_CYCLES)
    ) u_flash_timer (
        .clk   (clk),
        .reset (reset),
        .load  (timer_load),
        .zero  (timer_zero)
    );

    always_comb begin
        state_nx   = state;
        lives_nx   = lives;
        score_nx   = score;
        level_nx   = level;
        respawn_nx = 1'b0;
        timer_load = 1'b0;
        case (state)
            IDLE, GAME_OVER: begin
                if (start) begin
                    state_nx   = PLAY;
                    lives_nx   = LIVES_INIT;
                    score_nx   = '0;
                    level_nx   = '0;
                    respawn_nx = 1'b1;
                end
            end
            PLAY: begin
                // lost takes priority so a simultaneous won never scores
                if (lost) begin
                    state_nx   = LOSS_FLASH;
                    timer_load = 1'b1;
                    if (lives != '0) lives_nx = lives - LIVES_W'(1);
                end else if (won) begin
                    state_nx   = WIN_FLASH;
                    timer_load = 1'b1;
                    if (score < SCORE_MAX) score_nx = score + SCORE_W'(1);
                    if (level < LEVEL_MAX) level_nx = level + LEVEL_W'(1);
                end
            end
            WIN_FLASH: begin
                if (timer_zero) begin
                    state_nx   = PLAY;
                    respawn_nx = 1'b1;
                end
            end
            LOSS_FLASH: begin
                if (timer_zero) begin
                    if (lives == '0) begin
                        state_nx = GAME_OVER;
                    end else begin
                        state_nx   = PLAY;
                        respawn_nx = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign period_nx = PERIOD_0 - PERIOD_D * PERIOD_W'(level_nx);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            lives      <= LIVES_INIT;
            score      <= '0;
            level      <= '0;
            car_period <= PERIOD_0;
            respawn    <= 1'b0;
            freeze     <= 1'b1;
            flash      <= 1'b0;
            win_flash  <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            state      <= state_nx;
            lives      <= lives_nx;
            score      <= score_nx;
            level      <= level_nx;
            car_period <= period_nx;
            respawn    <= respawn_nx;
            freeze     <= (state_nx != PLAY);
            flash      <= (state_nx == WIN_FLASH) || (state_nx == LOSS_FLASH);
            win_flash  <= (state_nx == WIN_FLASH);
            game_over  <= (state_nx == GAME_OVER);
        end
    end

`ifdef FROG_HISCORE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hiscore <= '0;
        end else if (state_nx == GAME_OVER && state != GAME_OVER && score > hiscore) begin
            hiscore <= score;
        end
    end
`endif

endmodule

// File: tb/tb_frog_round_ctrl.sv
// Bench for frog_round_ctrl: vector table, directed corner sequences and random play vs a game model.
module tb_frog_round_ctrl;

    localparam int FC = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1, start = 1'b0, won = 1'b0, lost = 1'b0;
    logic       respawn, freeze, flash, win_flash, game_over;
    logic [1:0] lives;
    logic [6:0] score;
    logic [2:0] level;
    logic [4:0] car_period;
`ifdef FROG_HISCORE_EN
    logic [6:0] hiscore;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    frog_round_ctrl #(
        .LIVES(3),
        .FLASH_CYCLES(FC),
        .MAX_LEVEL(7),
        .BASE_PERIOD(24),
        .PERIOD_STEP(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .won(won), .lost(lost),
        .respawn(respawn), .freeze(freeze), .flash(flash), .win_flash(win_flash),
        .game_over(game_over), .lives(lives), .score(score), .level(level),
        .car_period(car_period)
`ifdef FROG_HISCORE_EN
        , .hiscore(hiscore)
`endif
    );

    // game model: what the player sees, tracked as play/over flags and remaining flash cycles
    bit m_play, m_over, m_win_kind, m_respawn;
    int m_flash_left, m_lives, m_score, m_level, m_hi;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit s, input bit w, input bit l);
        m_respawn = 0;
        if (r) begin
            m_play = 0; m_over = 0; m_flash_left = 0;
            m_lives = 3; m_score = 0; m_level = 0; m_hi = 0;
        end else if (m_flash_left > 0) begin
            m_flash_left--;
            if (m_flash_left == 0) begin
                if (!m_win_kind && m_lives == 0) begin
                    m_over = 1;
                    if (m_score > m_hi) m_hi = m_score;
                end else begin
                    m_play = 1; m_respawn = 1;
                end
            end
        end else if (m_play) begin
            if (l) begin
                m_play = 0; m_win_kind = 0; m_flash_left = FC;
                if (m_lives > 0) m_lives--;
            end else if (w) begin
                m_play = 0; m_win_kind = 1; m_flash_left = FC;
                m_score = (m_score + 1 > 99) ? 99 : m_score + 1;
                m_level = (m_level + 1 > 7) ? 7 : m_level + 1;
            end
        end else if (s) begin
            m_over = 0; m_play = 1; m_respawn = 1;
            m_lives = 3; m_score = 0; m_level = 0;
        end
    endtask

    task automatic step(input bit r, input bit s, input bit w, input bit l);
        @(negedge clk);
        reset = r; start = s; won = w; lost = l;
        @(posedge clk);
        #1;
        model_update(r, s, w, l);
        chk("model.lives", int'(lives), m_lives);
        chk("model.score", int'(score), m_score);
        chk("model.level", int'(level), m_level);
        chk("model.car_period", int'(car_period), 24 - 2 * m_level);
        chk("model.respawn", int'(respawn), int'(m_respawn));
        chk("model.freeze", int'(freeze), int'(!m_play));
        chk("model.flash", int'(flash), int'(m_flash_left > 0));
        chk("model.win_flash", int'(win_flash), int'(m_flash_left > 0 && m_win_kind));
        chk("model.game_over", int'(game_over), int'(m_over));
`ifdef FROG_HISCORE_EN
        chk("model.hiscore", int'(hiscore), m_hi);
`endif
    endtask

    task automatic win_round();
        step(0, 0, 1, 0);
        repeat (FC) step(0, 0, 0, 0);
    endtask

    task automatic lose_round();
        step(0, 0, 0, 1);
        repeat (FC) step(0, 0, 0, 0);
    endtask

    typedef struct {
        bit r, s, w, l;
        int lv, sc, lvl, fl, wf, fz, rs, go, per;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit r, s, w, l, input int lv, sc, lvl, fl, wf, fz, rs, go, per);
        vec_t v;
        v.r = r; v.s = s; v.w = w; v.l = l;
        v.lv = lv; v.sc = sc; v.lvl = lvl; v.fl = fl; v.wf = wf;
        v.fz = fz; v.rs = rs; v.go = go; v.per = per;
        tbl.push_back(v);
    endfunction

    initial begin
        //  r s w l   lv sc lvl fl wf fz rs go per
        add(1,0,0,0,  3, 0, 0, 0, 0, 1, 0, 0, 24);
        add(0,0,0,0,  3, 0, 0, 0, 0, 1, 0, 0, 24);
        add(0,1,0,0,  3, 0, 0, 0, 0, 0, 1, 0, 24);
        add(0,0,0,0,  3, 0, 0, 0, 0, 0, 0, 0, 24);
        add(0,0,1,0,  3, 1, 1, 1, 1, 1, 0, 0, 22);
        add(0,0,0,0,  3, 1, 1, 1, 1, 1, 0, 0, 22);
        add(0,0,1,0,  3, 1, 1, 1, 1, 1, 0, 0, 22);
        add(0,1,0,1,  3, 1, 1, 1, 1, 1, 0, 0, 22);
        add(0,0,0,0,  3, 1, 1, 0, 0, 0, 1, 0, 22);
        add(0,0,1,1,  2, 1, 1, 1, 0, 1, 0, 0, 22);
        add(0,0,1,0,  2, 1, 1, 1, 0, 1, 0, 0, 22);
        add(0,0,0,0,  2, 1, 1, 1, 0, 1, 0, 0, 22);
        add(0,0,0,0,  2, 1, 1, 1, 0, 1, 0, 0, 22);
        add(0,0,0,0,  2, 1, 1, 0, 0, 0, 1, 0, 22);
        add(0,0,0,1,  1, 1, 1, 1, 0, 1, 0, 0, 22);
        add(0,0,0,0,  1, 1, 1, 1, 0, 1, 0, 0, 22);
        add(0,0,0,0,  1, 1, 1, 1, 0, 1, 0, 0, 22);
        add(0,0,0,0,  1, 1, 1, 1, 0, 1, 0, 0, 22);
        add(0,0,0,0,  1, 1, 1, 0, 0, 0, 1, 0, 22);
        add(0,0,0,1,  0, 1, 1, 1, 0, 1, 0, 0, 22);
        add(0,0,0,0,  0, 1, 1, 1, 0, 1, 0, 0, 22);
        add(0,0,0,0,  0, 1, 1, 1, 0, 1, 0, 0, 22);
        add(0,0,0,0,  0, 1, 1, 1, 0, 1, 0, 0, 22);
        add(0,0,0,0,  0, 1, 1, 0, 0, 1, 0, 1, 22);
        add(0,0,0,1,  0, 1, 1, 0, 0, 1, 0, 1, 22);
        add(0,1,0,0,  3, 0, 0, 0, 0, 0, 1, 0, 24);
        add(0,1,0,0,  3, 0, 0, 0, 0, 0, 0, 0, 24);

        for (int unsigned i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].s, tbl[i].w, tbl[i].l);
            chk($sformatf("vec%0d.lives", i), int'(lives), tbl[i].lv);
            chk($sformatf("vec%0d.score", i), int'(score), tbl[i].sc);
            chk($sformatf("vec%0d.level", i), int'(level), tbl[i].lvl);
            chk($sformatf("vec%0d.flash", i), int'(flash), tbl[i].fl);
            chk($sformatf("vec%0d.win_flash", i), int'(win_flash), tbl[i].wf);
            chk($sformatf("vec%0d.freeze", i), int'(freeze), tbl[i].fz);
            chk($sformatf("vec%0d.respawn", i), int'(respawn), tbl[i].rs);
            chk($sformatf("vec%0d.game_over", i), int'(game_over), tbl[i].go);
            chk($sformatf("vec%0d.car_period", i), int'(car_period), tbl[i].per);
        end

        // level saturation after nine wins
        repeat (9) win_round();
        chk("sat.level", int'(level), 7);
        chk("sat.car_period", int'(car_period), 10);
        chk("sat.score9", int'(score), 9);

        // score saturation at 99
        repeat (90) win_round();
        chk("sat.score99", int'(score), 99);
        step(0, 0, 1, 0);
        chk("sat.score_hold", int'(score), 99);
        chk("sat.win_flash", int'(win_flash), 1);
        repeat (FC) step(0, 0, 0, 0);

        // reset sampled at the end of the second WIN_FLASH cycle
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        chk("midflash.flash_before", int'(flash), 1);
        step(1, 0, 0, 0);
        chk("midflash.flash", int'(flash), 0);
        chk("midflash.score", int'(score), 0);
        chk("midflash.freeze", int'(freeze), 1);
        chk("midflash.respawn", int'(respawn), 0);
        chk("midflash.game_over", int'(game_over), 0);

        // two games: score 5 then score 3
        step(0, 1, 0, 0);
        repeat (5) win_round();
        repeat (3) lose_round();
        chk("go1.game_over", int'(game_over), 1);
        chk("go1.score", int'(score), 5);
        chk("go1.respawn", int'(respawn), 0);
`ifdef FROG_HISCORE_EN
        chk("go1.hiscore", int'(hiscore), 5);
`endif
        step(0, 1, 0, 0);
        repeat (3) win_round();
        repeat (3) lose_round();
        chk("go2.score", int'(score), 3);
        chk("go2.game_over", int'(game_over), 1);
`ifdef FROG_HISCORE_EN
        chk("go2.hiscore", int'(hiscore), 5);
`endif

        // random play against the model
        for (int unsigned i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 6) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
